// File: rtl/pim_mem_pkg.sv
// Shared types and helpers for the PIM memory controller.
// Holds the FSM state enum, the IO error pattern and the IO window decode.
package pim_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAM_WR,
        RAM_RD,
        IO_WR,
        IO_RD,
        IO_WAIT_W,
        IO_WAIT_R
    } mem_state_t;

    localparam logic [31:0] IO_ERR_DATA = 32'hDEAD_BEEF;

    // Store payload latched at acceptance; shared by the RAM and IO write ports.
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_req_t;

    // 33-bit compare so a window ending exactly at 2^32 does not wrap.
    function automatic logic is_io_addr(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned nch);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + 33'(4 * nch);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/pim_io_wait_timer.sv
// Counts busy cycles in an IO wait state and flags when the limit is reached.
// Instantiated only when MEMCTRL_IO_TIMEOUT_EN is defined.
module pim_io_wait_timer #(
    parameter int IO_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic busy,
    output logic limit_hit
);

    localparam int CW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT + 1) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (busy)
            count <= count + 1'b1;
    end

    // Fires on the busy cycle that would bring the count to IO_TIMEOUT.
    assign limit_hit = busy && (count == CW'(IO_TIMEOUT - 1));

endmodule

// File: rtl/pim_mem_controller.sv
// Core load/store port to on-chip RAM plus IO_CH memory-mapped IO channels.
// Optional IO wait timeout with sticky error: define MEMCTRL_IO_TIMEOUT_EN.
module pim_mem_controller
    import pim_mem_pkg::*;
#(
    parameter int          RAM_AW     = 10,
    parameter int          RAM_RD_LAT = 1,
    parameter int          IO_CH      = 4,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FFF0,
    parameter int          IO_TIMEOUT = 255,
    localparam int         CH_W       = (IO_CH > 1) ? $clog2(IO_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       riscv_addr,
    input  logic [31:0]       riscv_wdata,
    input  logic [3:0]        riscv_wmask,
    input  logic              riscv_rstrb,
    input  logic              riscv_wen,
    output logic [31:0]       riscv_rdata,
    output logic              riscv_rbusy,
    output logic              riscv_wbusy,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_byteena,
    output logic              ram_wen,
    output logic              ram_rden,
    input  logic [31:0]       ram_rdata,
    output logic [CH_W-1:0]   io_ch,
    output logic [31:0]       io_wdata,
    output logic [3:0]        io_wmask,
    output logic              io_wen,
    output logic              io_ren,
    input  logic [31:0]       io_rdata,
    input  logic [IO_CH-1:0]  io_busy,
    output logic              io_timeout_err
);

    if (RAM_RD_LAT < 1 || RAM_RD_LAT > 4 || IO_CH < 1 || IO_CH > 16 || IO_TIMEOUT < 1) begin : g_bad_param
        $error("pim_mem_controller: parameter out of range");
    end

    mem_state_t          state_q;
    mem_state_t          state_d;
    logic [RAM_RD_LAT:0] vld_pipe;
    wr_req_t             req_q;
    logic                io_hit;
    logic                accept;
    logic                rd_go;
    logic                sel_busy;
    logic                tmo;

    assign io_hit   = is_io_addr(riscv_addr, IO_BASE, IO_CH);
    assign accept   = (state_q == IDLE) && (riscv_wen || riscv_rstrb);
    assign rd_go    = (state_q == IDLE) && (state_d == RAM_RD);
    assign sel_busy = io_busy[io_ch];

    always_comb begin
        state_d     = state_q;
        riscv_wbusy = 1'b0;
        riscv_rbusy = 1'b0;
        ram_wen     = 1'b0;
        io_wen      = 1'b0;
        io_ren      = 1'b0;
        case (state_q)
            IDLE: begin
                // Store wins over a coincident load; the load is dropped.
                if (riscv_wen)
                    state_d = io_hit ? IO_WR : RAM_WR;
                else if (riscv_rstrb)
                    state_d = io_hit ? IO_RD : RAM_RD;
            end
            RAM_WR: begin
                riscv_wbusy = 1'b1;
                ram_wen     = 1'b1;
                state_d     = IDLE;
            end
            RAM_RD: begin
                riscv_rbusy = 1'b1;
                if (vld_pipe[RAM_RD_LAT])
                    state_d = IDLE;
            end
            IO_WR: begin
                riscv_wbusy = 1'b1;
                io_wen      = 1'b1;
                state_d     = IO_WAIT_W;
            end
            IO_RD: begin
                riscv_rbusy = 1'b1;
                io_ren      = 1'b1;
                state_d     = IO_WAIT_R;
            end
            IO_WAIT_W: begin
                riscv_wbusy = 1'b1;
                if (!sel_busy || tmo)
                    state_d = IDLE;
            end
            IO_WAIT_R: begin
                riscv_rbusy = 1'b1;
                if (!sel_busy || tmo)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // vld_pipe[0] marks the read-enable cycle; vld_pipe[RAM_RD_LAT] is the data cycle.
    assign ram_rden = vld_pipe[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            vld_pipe    <= '0;
            req_q       <= '0;
            ram_addr    <= '0;
            io_ch       <= '0;
            riscv_rdata <= '0;
        end else begin
            state_q  <= state_d;
            vld_pipe <= {vld_pipe[RAM_RD_LAT-1:0], rd_go};
            if (accept) begin
                ram_addr <= riscv_addr[RAM_AW+1:2];
                io_ch    <= CH_W'((riscv_addr - IO_BASE) >> 2);
                req_q    <= '{data: riscv_wdata, mask: riscv_wmask};
            end
            if (state_q == RAM_RD && vld_pipe[RAM_RD_LAT])
                riscv_rdata <= ram_rdata;
            else if (state_q == IO_WAIT_R && !sel_busy)
                riscv_rdata <= io_rdata;
            else if (state_q == IO_WAIT_R && tmo)
                riscv_rdata <= IO_ERR_DATA;
        end
    end

    assign ram_wdata   = req_q.data;
    assign ram_byteena = req_q.mask;
    assign io_wdata    = req_q.data;
    assign io_wmask    = req_q.mask;

`ifdef MEMCTRL_IO_TIMEOUT_EN
    logic wait_clr;
    logic wait_busy;
    logic err_q;

    // Counter restarts on the pulse cycle, i.e. just before entering a wait state.
    assign wait_clr  = (state_q == IO_WR) || (state_q == IO_RD);
    assign wait_busy = ((state_q == IO_WAIT_W) || (state_q == IO_WAIT_R)) && sel_busy;

    pim_io_wait_timer #(
        .IO_TIMEOUT (IO_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (wait_clr),
        .busy      (wait_busy),
        .limit_hit (tmo)
    );

    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (tmo)
            err_q <= 1'b1;
    end

    assign io_timeout_err = err_q;
`else
    assign tmo            = 1'b0;
    assign io_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pim_mem_controller.sv
// Directed bench for pim_mem_controller: table of single transactions plus
// hand sequences for ignored strobes, collisions, back-to-back and reset.
module tb_pim_mem_controller;

    localparam int LAT = 2;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] riscv_addr = '0;
    logic [31:0] riscv_wdata = '0;
    logic [3:0]  riscv_wmask = '0;
    logic        riscv_rstrb = 1'b0;
    logic        riscv_wen = 1'b0;
    logic [31:0] riscv_rdata;
    logic        riscv_rbusy;
    logic        riscv_wbusy;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_byteena;
    logic        ram_wen;
    logic        ram_rden;
    logic [31:0] ram_rdata;
    logic [1:0]  io_ch;
    logic [31:0] io_wdata;
    logic [3:0]  io_wmask;
    logic        io_wen;
    logic        io_ren;
    logic [31:0] io_rdata = '0;
    logic [3:0]  io_busy = '0;
    logic        io_timeout_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pim_mem_controller #(
        .RAM_AW     (10),
        .RAM_RD_LAT (LAT),
        .IO_CH      (4),
        .IO_BASE    (32'hFFFF_FFF0),
        .IO_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .riscv_addr     (riscv_addr),
        .riscv_wdata    (riscv_wdata),
        .riscv_wmask    (riscv_wmask),
        .riscv_rstrb    (riscv_rstrb),
        .riscv_wen      (riscv_wen),
        .riscv_rdata    (riscv_rdata),
        .riscv_rbusy    (riscv_rbusy),
        .riscv_wbusy    (riscv_wbusy),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_byteena    (ram_byteena),
        .ram_wen        (ram_wen),
        .ram_rden       (ram_rden),
        .ram_rdata      (ram_rdata),
        .io_ch          (io_ch),
        .io_wdata       (io_wdata),
        .io_wmask       (io_wmask),
        .io_wen         (io_wen),
        .io_ren         (io_ren),
        .io_rdata       (io_rdata),
        .io_busy        (io_busy),
        .io_timeout_err (io_timeout_err)
    );

    // RAM model: data appears LAT cycles after the read-enable cycle, junk otherwise.
    logic [31:0] ram_val = '0;
    logic [31:0] rp [LAT];
    always @(posedge clk) begin
        rp[0] <= ram_rden ? ram_val : 32'h0BAD_0000;
        for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
    end
    assign ram_rdata = rp[LAT-1];

    // Coincident strobes in IDLE: the store must be taken and the load dropped.
    logic both_q = 1'b0;
    always @(posedge clk)
        both_q <= !reset && riscv_wen && riscv_rstrb && !riscv_wbusy && !riscv_rbusy;
    always @(negedge clk)
        if (both_q)
            assert (riscv_wbusy && !riscv_rbusy)
            else $error("FAIL simultaneous_strobe wbusy=%b rbusy=%b required 1/0", riscv_wbusy, riscv_rbusy);

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        bit          wr;
        bit          io;
        logic [31:0] rsp;
        int          k;
        int          exp_busy;
        logic [15:0] exp_pulse;   // {io_ren, io_wen, ram_rden, ram_wen} cycle counts
        logic [31:0] exp_loc;     // ram_addr for RAM, io_ch for IO
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

`ifdef MEMCTRL_IO_TIMEOUT_EN
    localparam int          LONG_BUSY  = 1 + TMO;
    localparam logic [31:0] LONG_RDATA = 32'hDEAD_BEEF;
    localparam logic        EXP_ERR    = 1'b1;
`else
    localparam int          LONG_BUSY  = 22;
    localparam logic [31:0] LONG_RDATA = 32'h1111_2222;
    localparam logic        EXP_ERR    = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdata"}, riscv_rdata, 32'h0);
        chk({tag, "_ctl"}, {25'd0, riscv_rbusy, riscv_wbusy, ram_wen, ram_rden, io_wen, io_ren, io_timeout_err}, 32'h0);
        chk({tag, "_ram_addr"}, {22'd0, ram_addr}, 32'h0);
        chk({tag, "_ram_wdata"}, ram_wdata, 32'h0);
        chk({tag, "_byteena"}, {28'd0, ram_byteena}, 32'h0);
        chk({tag, "_io_ch"}, {30'd0, io_ch}, 32'h0);
        chk({tag, "_io_wdata"}, io_wdata, 32'h0);
        chk({tag, "_io_wmask"}, {28'd0, io_wmask}, 32'h0);
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        int          nb, nx, n_cw, n_cr, n_iw, n_ir, ch;
        bit          done;
        logic [31:0] loc_s, wd_s;
        logic [3:0]  m_s;
        v = vecs[idx];
        nb = 0; nx = 0; n_cw = 0; n_cr = 0; n_iw = 0; n_ir = 0; done = 0;
        ch = int'(v.exp_loc[1:0]);
        @(negedge clk);
        riscv_addr  = v.addr;
        riscv_wdata = v.wdata;
        riscv_wmask = v.wmask;
        riscv_wen   = v.wr;
        riscv_rstrb = !v.wr;
        ram_val     = v.rsp;
        if (v.io) begin
            io_busy     = 4'hF;
            io_busy[ch] = (v.k > 0);
            io_rdata    = (v.k > 0) ? 32'h0BAD_0BAD : v.rsp;
        end
        @(negedge clk);
        riscv_wen   = 1'b0;
        riscv_rstrb = 1'b0;
        loc_s = v.io ? {30'd0, io_ch} : {22'd0, ram_addr};
        wd_s  = v.io ? io_wdata : ram_wdata;
        m_s   = v.io ? io_wmask : ram_byteena;
        for (int i = 0; i < 60 && !done; i++) begin
            if (v.wr ? !riscv_wbusy : !riscv_rbusy) done = 1;
            else nb++;
            if (v.wr ? riscv_rbusy : riscv_wbusy) nx++;
            n_cw += int'(ram_wen);
            n_cr += int'(ram_rden);
            n_iw += int'(io_wen);
            n_ir += int'(io_ren);
            if (v.io && v.k > 0 && i == v.k + 1) begin
                io_busy[ch] = 1'b0;
                io_rdata    = v.rsp;
            end
            if (!done) @(negedge clk);
        end
        io_busy = '0;
        chk($sformatf("v%0d_bound", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d_busy_len", idx), nb, v.exp_busy);
        chk($sformatf("v%0d_other_busy", idx), nx, 0);
        chk($sformatf("v%0d_pulses", idx), {16'd0, 4'(n_ir), 4'(n_iw), 4'(n_cr), 4'(n_cw)}, {16'd0, v.exp_pulse});
        chk($sformatf("v%0d_loc", idx), loc_s, v.exp_loc);
        if (v.wr) begin
            chk($sformatf("v%0d_wdata", idx), wd_s, v.wdata);
            chk($sformatf("v%0d_mask", idx), {28'd0, m_s}, {28'd0, v.wmask});
        end else begin
            chk($sformatf("v%0d_rdata", idx), riscv_rdata, v.exp_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int  nb, nw;
        bit  done;

        vecs[0] = '{addr:32'h0000_0004, wdata:32'hABCD_1234, wmask:4'b0011, wr:1, io:0, rsp:32'h0,
                    k:0, exp_busy:1, exp_pulse:16'h0001, exp_loc:32'd1, exp_rdata:32'h0};
        vecs[1] = '{addr:32'h0000_0004, wdata:32'h0, wmask:4'b0, wr:0, io:0, rsp:32'h8765_4321,
                    k:0, exp_busy:LAT+1, exp_pulse:16'h0010, exp_loc:32'd1, exp_rdata:32'h8765_4321};
        vecs[2] = '{addr:32'hFFFF_FFFF, wdata:32'h1234_5678, wmask:4'b1111, wr:1, io:1, rsp:32'h0,
                    k:3, exp_busy:5, exp_pulse:16'h0100, exp_loc:32'd3, exp_rdata:32'h0};
        vecs[3] = '{addr:32'hFFFF_FFF4, wdata:32'h0, wmask:4'b0, wr:0, io:1, rsp:32'hDEAD_0001,
                    k:0, exp_busy:2, exp_pulse:16'h1000, exp_loc:32'd1, exp_rdata:32'hDEAD_0001};
        vecs[4] = '{addr:32'h0001_0008, wdata:32'h5A5A_A5A5, wmask:4'b1100, wr:1, io:0, rsp:32'h0,
                    k:0, exp_busy:1, exp_pulse:16'h0001, exp_loc:32'd2, exp_rdata:32'h0};
        vecs[5] = '{addr:32'hFFFF_FFF0, wdata:32'hCAFE_F00D, wmask:4'b0101, wr:1, io:1, rsp:32'h0,
                    k:0, exp_busy:2, exp_pulse:16'h0100, exp_loc:32'd0, exp_rdata:32'h0};
        vecs[6] = '{addr:32'hFFFF_FFEC, wdata:32'h0, wmask:4'b0, wr:0, io:0, rsp:32'h0102_0304,
                    k:0, exp_busy:LAT+1, exp_pulse:16'h0010, exp_loc:32'h3FB, exp_rdata:32'h0102_0304};
        vecs[7] = '{addr:32'hFFFF_FFFA, wdata:32'h0, wmask:4'b0, wr:0, io:1, rsp:32'h0BEE_0002,
                    k:2, exp_busy:4, exp_pulse:16'h1000, exp_loc:32'd2, exp_rdata:32'h0BEE_0002};
        vecs[8] = '{addr:32'hFFFF_FFF0, wdata:32'h0, wmask:4'b0, wr:0, io:1, rsp:32'h1111_2222,
                    k:20, exp_busy:LONG_BUSY, exp_pulse:16'h1000, exp_loc:32'd0, exp_rdata:LONG_RDATA};

        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i);
        chk("timeout_err_set", {31'd0, io_timeout_err}, {31'd0, EXP_ERR});

        // A: store strobe during a RAM read is ignored.
        @(negedge clk);
        riscv_addr = 32'h0000_0008; riscv_rstrb = 1'b1; ram_val = 32'h7777_0008;
        @(negedge clk);
        riscv_rstrb = 1'b0;
        nb = 0; nw = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (!riscv_rbusy) done = 1;
            else nb++;
            nw += int'(riscv_wbusy) + int'(ram_wen) + int'(io_wen);
            if (i == 1) begin
                riscv_wen = 1'b1; riscv_addr = 32'hFFFF_FFF0; riscv_wdata = 32'h5555_5555;
            end
            if (i == 2) riscv_wen = 1'b0;
            if (!done) @(negedge clk);
        end
        repeat (2) begin
            @(negedge clk);
            nw += int'(riscv_wbusy);
        end
        chk("seqA_bound", {31'd0, done}, 32'd1);
        chk("seqA_rbusy_len", nb, LAT + 1);
        chk("seqA_ignored_wr", nw, 0);
        chk("seqA_rdata", riscv_rdata, 32'h7777_0008);
        chk("seqA_ram_addr", {22'd0, ram_addr}, 32'd2);

        // B: coincident strobes, store taken.
        @(negedge clk);
        riscv_addr = 32'h0000_000C; riscv_wdata = 32'h0F0F_0F0F; riscv_wmask = 4'hF;
        riscv_wen = 1'b1; riscv_rstrb = 1'b1;
        @(negedge clk);
        riscv_wen = 1'b0; riscv_rstrb = 1'b0;
        chk("seqB_ctl", {28'd0, riscv_wbusy, riscv_rbusy, ram_wen, ram_rden}, 32'b1010);
        chk("seqB_ram_addr", {22'd0, ram_addr}, 32'd3);
        @(negedge clk);
        chk("seqB_idle", {30'd0, riscv_wbusy, riscv_rbusy}, 32'd0);
        chk("seqB_rdata_held", riscv_rdata, 32'h7777_0008);

        // C: back-to-back writes, second accepted in the first IDLE cycle.
        riscv_addr = 32'h0000_0010; riscv_wdata = 32'h1; riscv_wen = 1'b1;
        @(negedge clk);
        riscv_wen = 1'b0;
        chk("seqC_first", {26'd0, riscv_wbusy, ram_addr[4:0]}, {26'd0, 1'b1, 5'd4});
        @(negedge clk);
        chk("seqC_gap", {31'd0, riscv_wbusy}, 32'd0);
        riscv_addr = 32'h0000_0014; riscv_wdata = 32'h2; riscv_wen = 1'b1;
        @(negedge clk);
        riscv_wen = 1'b0;
        chk("seqC_second", {29'd0, riscv_wbusy, ram_wen, 1'b0}, 32'b110);
        chk("seqC_addr", {22'd0, ram_addr}, 32'd5);
        chk("seqC_wdata", ram_wdata, 32'h2);
        @(negedge clk);
        chk("seqC_done", {31'd0, riscv_wbusy}, 32'd0);
        chk("timeout_err_sticky", {31'd0, io_timeout_err}, {31'd0, EXP_ERR});

        // D: reset during RAM_RD drops the read; next write proceeds.
        riscv_addr = 32'h0000_0020; riscv_rstrb = 1'b1; ram_val = 32'h9999_0020;
        @(negedge clk);
        riscv_rstrb = 1'b0;
        chk("seqD_rbusy", {31'd0, riscv_rbusy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("rstmid");
        reset = 1'b0;
        @(negedge clk);
        riscv_addr = 32'h0000_0024; riscv_wdata = 32'h3; riscv_wmask = 4'b0001; riscv_wen = 1'b1;
        @(negedge clk);
        riscv_wen = 1'b0;
        chk("seqD_wr", {30'd0, riscv_wbusy, ram_wen}, 32'b11);
        chk("seqD_addr", {22'd0, ram_addr}, 32'd9);
        chk("seqD_mask", {28'd0, ram_byteena}, 32'b0001);
        @(negedge clk);
        chk("seqD_done", {31'd0, riscv_wbusy}, 32'd0);
        chk("seqD_rdata", riscv_rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pim_mem_controller.md
# pim_mem_controller

Parametrised successor to the single-port RAM/IO controller. Sits between the RISC-V core's load/store port and the on-chip RAM IP plus a bank of memory-mapped IO channels. Decodes each core access to RAM or one of `IO_CH` IO channels. Adds configurable RAM read latency, per-channel busy handshakes, and an optional IO timeout with error reporting.

## Interface

**Parameters**
- `RAM_AW`, default 10: RAM word-address width.
- `RAM_RD_LAT`, default 1: cycles from `ram_rden` to valid `ram_rdata`. Legal range is 1–4.
- `IO_CH`, default 4: number of IO channels, 1–16.
- `IO_BASE`, default 32'hFFFF_FFF0: base of the IO window. Must be word-aligned, with `IO_BASE + 4*IO_CH` ≤ 2^32.
- `IO_TIMEOUT`, default 255: wait-cycle limit. Used only with the macro.

**Ports**
- `clk` in 1: the single clock. Rising edge.
- `reset` in 1: synchronous, active-high reset.
- `riscv_addr` in 32: byte address.
- `riscv_wdata` in 32: store data.
- `riscv_wmask` in 4: store byte mask.
- `riscv_rstrb` in 1: load request, one-cycle pulse.
- `riscv_wen` in 1: store request, one-cycle pulse.
- `riscv_rdata` out 32: load data.
- `riscv_rbusy` out 1: load in progress.
- `riscv_wbusy` out 1: store in progress.
- `ram_addr` out RAM_AW: RAM word address, equal to `riscv_addr[RAM_AW+1:2]`.
- `ram_wdata` out 32, `ram_byteena` out 4: RAM write data and byte enables.
- `ram_wen` out 1, `ram_rden` out 1: RAM write and read enables.
- `ram_rdata` in 32: RAM read data.
- `io_ch` out $clog2(IO_CH) (minimum 1): selected channel.
- `io_wdata` out 32, `io_wmask` out 4: IO write data and mask.
- `io_wen` out 1, `io_ren` out 1: IO write and read pulses.
- `io_rdata` in 32: read data from the selected channel.
- `io_busy` in IO_CH: per-channel busy flags.
- `io_timeout_err` out 1: sticky timeout flag.

## Operation

- **Decode.** An address in [`IO_BASE`, `IO_BASE + 4*IO_CH`) targets IO, with channel = `(addr - IO_BASE) >> 2`.
  - The low byte bits are ignored, so the legacy address 0xFFFF_FFFF maps to channel 3 with the default parameters.
  - Every other address targets RAM. Bits above `RAM_AW+1` are ignored, so RAM aliases across the address space.
- **Acceptance.** A request is accepted only in IDLE. Strobes arriving in any other state are ignored.
- **Simultaneous strobes.** If `riscv_wen` and `riscv_rstrb` are asserted together, the write is taken and the read is dropped. The bench flags this with an assertion.
- **States:** IDLE, RAM_WR, RAM_RD, IO_WR, IO_RD, IO_WAIT_W, IO_WAIT_R.
  - IDLE → RAM_WR / RAM_RD / IO_WR / IO_RD on an accepted request.
  - RAM_WR: `ram_wen` = 1 for one cycle, then IDLE.
  - RAM_RD: `ram_rden` = 1 for the first cycle. A latency counter runs `RAM_RD_LAT` cycles, then `ram_rdata` is captured into `riscv_rdata` and the FSM returns to IDLE.
  - IO_WR and IO_RD: `io_wen` or `io_ren` = 1 for one cycle, then IO_WAIT_W or IO_WAIT_R.
  - IO_WAIT_*: `io_busy[io_ch]` is sampled each cycle. When it is 0, the FSM returns to IDLE. For a read, `io_rdata` is captured in that same cycle.
- **Registered outputs.** Address, data, mask and channel outputs are registered at acceptance and held until the next acceptance.
- **Output reset values.** Every output resets to 0, including `riscv_rdata`, all enables, both busies, `io_ch` and `io_timeout_err`.
- **Reset mid-transaction.** The transaction is dropped and all outputs take their reset values at that edge. No partial write is retried.

## Timing

- Request sampled at edge *t*. The corresponding busy output is high from *t*+ until the completing edge.
- RAM write: `wbusy` is high for exactly 1 cycle.
- RAM read: `rbusy` is high for `RAM_RD_LAT + 1` cycles. `riscv_rdata` is valid when `rbusy` falls and holds until the next read completes.
- IO write or read with `io_busy` low: busy is high for 2 cycles (pulse cycle plus one wait sample).
- IO with `io_busy` high for *k* wait samples: busy is high for 2 + *k* cycles.
- Back-to-back requests: a new strobe is accepted in the first IDLE cycle, so there is no bubble beyond the busy period.

## Configuration

**`MEMCTRL_IO_TIMEOUT_EN` defined**
- A wait counter clears on entering IO_WAIT_* and increments each busy cycle.
- When the count reaches `IO_TIMEOUT`, the FSM aborts to IDLE.
  - For a read, `riscv_rdata` = 32'hDEAD_BEEF.
  - `io_timeout_err` sets and stays set until `reset`.

**`MEMCTRL_IO_TIMEOUT_EN` undefined**
- The FSM waits indefinitely.
- `io_timeout_err` is tied to 0 and no counter is built.

## Structure

- Package `pim_mem_pkg` holds:
  - the state enum `mem_state_t`;
  - the constant `IO_ERR_DATA` = 32'hDEAD_BEEF;
  - the address-decode function `is_io_addr`.
- One sub-module, `pim_io_wait_timer`, holds the wait counter and the timeout compare. It is instantiated only under the macro.

## Test plan

- RAM write to 0x0000_0004, data 0xABCD_1234, mask 4'b0011 → `ram_addr` = 1, `ram_byteena` = 0011, `ram_wen` pulses once, `wbusy` is high for 1 cycle.
- RAM read at 0x0000_0004 with `RAM_RD_LAT` = 2 and `ram_rdata` = 0x8765_4321 → `rbusy` is high for 3 cycles, then `riscv_rdata` = 0x8765_4321.
- IO write to 0xFFFF_FFFF, data 0x1234_5678, with `io_busy[3]` held high 3 cycles → `io_ch` = 3, one `io_wen` pulse, `wbusy` is high for 5 cycles.
- IO read from channel 1 (0xFFFF_FFF4) with `io_rdata` = 0xDEAD_0001 and busy 0 → `rbusy` is high for 2 cycles, `riscv_rdata` = 0xDEAD_0001.
- With the macro defined and `IO_TIMEOUT` = 8, hold `io_busy[0]` high on a read → abort after 8 wait cycles, `riscv_rdata` = 0xDEAD_BEEF, `io_timeout_err` = 1 until `reset`.
- Assert `reset` during RAM_RD → all outputs 0 at the next edge. A subsequent write is accepted normally.
